// File: rtl/pe_array_sched.sv
// Sequencer for the row-stationary PE array: programs PE tags, streams filter/ifmap rows,
// runs MAC and psum accumulation, then strobes row-0 outputs for one pass.
module pe_array_sched #(
  parameter int unsigned GRID_X = 10,
  parameter int unsigned GRID_Y = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_rows,
  input  logic [3:0]        cfg_cols,
  input  logic [4:0]        cfg_filt_len,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        control,
  output logic [GRID_X-1:0] enable_x,
  output logic [GRID_Y-1:0] enable_y,
  output logic [4:0]        filter_id,
  output logic [5:0]        ifmap_id,
  output logic              psum_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle, StProg, StLoadF, StLoadI, StMac, StAccum, StOut, StDone
  } state_e;

  localparam logic [3:0] CtlIdle  = 4'd0;
  localparam logic [3:0] CtlProg  = 4'd1;
  localparam logic [3:0] CtlLoadF = 4'd2;
  localparam logic [3:0] CtlLoadI = 4'd3;
  localparam logic [3:0] CtlMac   = 4'd4;
  localparam logic [3:0] CtlAccum = 4'd5;
  localparam logic [3:0] CtlOut   = 4'd6;

  localparam logic [GRID_X-1:0] OneX = GRID_X'(1);
  localparam logic [GRID_Y-1:0] OneY = GRID_Y'(1);

  state_e state_q, state_d;
  logic [3:0] r_q, r_d, e_q, e_d;
  logic [4:0] s_q, s_d;
  // a: outer counter (row / ifmap row / cycle); b: inner counter (column / word)
  logic [4:0] a_q, a_d, b_q, b_d;

  logic [3:0]        control_q, control_d;
  logic [GRID_X-1:0] enable_x_q, enable_x_d;
  logic [GRID_Y-1:0] enable_y_q, enable_y_d;
  logic [4:0]        filter_id_q, filter_id_d;
  logic [5:0]        ifmap_id_q, ifmap_id_d;
  logic              psum_valid_q, psum_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0] rows_clip, cols_clip;
  logic [4:0] filt_clip;
  logic [4:0] r5, e5;
  logic       xfer, in_load;

  always_comb begin
    rows_clip = cfg_rows;
    if (cfg_rows == 4'd0) rows_clip = 4'd1;
    else if (cfg_rows > 4'(GRID_Y)) rows_clip = 4'(GRID_Y);
    cols_clip = cfg_cols;
    if (cfg_cols == 4'd0) cols_clip = 4'd1;
    else if (cfg_cols > 4'(GRID_X)) cols_clip = 4'(GRID_X);
    filt_clip = (cfg_filt_len == 5'd0) ? 5'd1 : cfg_filt_len;
  end

  assign r5      = {1'b0, r_q};
  assign e5      = {1'b0, e_q};
  assign in_load = (state_q == StLoadF) || (state_q == StLoadI);
  assign xfer    = in_load && data_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= 4'd0;
      e_q     <= 4'd0;
      s_q     <= 5'd0;
      a_q     <= 5'd0;
      b_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      e_q     <= e_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    e_d     = e_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StProg;
          r_d     = rows_clip;
          e_d     = cols_clip;
          s_d     = filt_clip;
          a_d     = 5'd0;
          b_d     = 5'd0;
        end
      end
      StProg: begin
        if (b_q == e5 - 5'd1) begin
          b_d = 5'd0;
          if (a_q == r5 - 5'd1) begin
            a_d     = 5'd0;
            state_d = StLoadF;
          end else begin
            a_d = a_q + 5'd1;
          end
        end else begin
          b_d = b_q + 5'd1;
        end
      end
      StLoadF: begin
        if (xfer) begin
          if (b_q == s_q - 5'd1) begin
            b_d = 5'd0;
            if (a_q == r5 - 5'd1) begin
              a_d     = 5'd0;
              state_d = StLoadI;
            end else begin
              a_d = a_q + 5'd1;
            end
          end else begin
            b_d = b_q + 5'd1;
          end
        end
      end
      StLoadI: begin
        if (xfer) begin
          if (b_q == s_q - 5'd1) begin
            b_d = 5'd0;
            if (a_q == r5 + e5 - 5'd2) begin
              a_d     = 5'd0;
              state_d = StMac;
            end else begin
              a_d = a_q + 5'd1;
            end
          end else begin
            b_d = b_q + 5'd1;
          end
        end
      end
      StMac: begin
        if (a_q == s_q - 5'd1) begin
          a_d     = 5'd0;
          state_d = (r_q == 4'd1) ? StOut : StAccum;
        end else begin
          a_d = a_q + 5'd1;
        end
      end
      StAccum: begin
        if (a_q == r5 - 5'd2) begin
          a_d     = 5'd0;
          state_d = StOut;
        end else begin
          a_d = a_q + 5'd1;
        end
      end
      StOut:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from next state so the registered outputs line up with the state they describe
  always_comb begin
    control_d    = CtlIdle;
    enable_x_d   = '0;
    enable_y_d   = '0;
    filter_id_d  = 5'd0;
    ifmap_id_d   = 6'd0;
    psum_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      StProg: begin
        control_d   = CtlProg;
        enable_x_d  = OneX << b_d;
        enable_y_d  = OneY << a_d;
        filter_id_d = a_d;
        ifmap_id_d  = {1'b0, a_d} + {1'b0, b_d};
        busy_d      = 1'b1;
      end
      StLoadF: begin
        control_d   = CtlLoadF;
        enable_x_d  = (OneX << e_d) - OneX;
        enable_y_d  = OneY << a_d;
        filter_id_d = a_d;
        busy_d      = 1'b1;
      end
      StLoadI: begin
        control_d  = CtlLoadI;
        enable_x_d = (OneX << e_d) - OneX;
        enable_y_d = (OneY << r_d) - OneY;
        ifmap_id_d = {1'b0, a_d};
        busy_d     = 1'b1;
      end
      StMac, StAccum: begin
        control_d  = (state_d == StMac) ? CtlMac : CtlAccum;
        enable_x_d = (OneX << e_d) - OneX;
        enable_y_d = (OneY << r_d) - OneY;
        busy_d     = 1'b1;
      end
      StOut: begin
        control_d    = CtlOut;
        enable_x_d   = (OneX << e_d) - OneX;
        enable_y_d   = OneY;
        psum_valid_d = 1'b1;
        busy_d       = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      control_q    <= CtlIdle;
      enable_x_q   <= '0;
      enable_y_q   <= '0;
      filter_id_q  <= 5'd0;
      ifmap_id_q   <= 6'd0;
      psum_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      control_q    <= control_d;
      enable_x_q   <= enable_x_d;
      enable_y_q   <= enable_y_d;
      filter_id_q  <= filter_id_d;
      ifmap_id_q   <= ifmap_id_d;
      psum_valid_q <= psum_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_ready = in_load;
  // Stall cycles in the load phases present IDLE so PEs ignore the bus
  assign control    = (in_load && !data_valid) ? CtlIdle : control_q;
  assign enable_x   = enable_x_q;
  assign enable_y   = enable_y_q;
  assign filter_id  = filter_id_q;
  assign ifmap_id   = ifmap_id_q;
  assign psum_valid = psum_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
